// File: rtl/vlc_blk_sched_pkg.sv
// Shared types and defaults for the VLC block scheduler: FSM encoding, timing defaults
// and the block-index to component-select decode.
package vlc_blk_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StIssue,
        StGap,
        StDone
    } sched_state_e;

    localparam int unsigned BlkLenDef      = 64;
    localparam int unsigned GapCycDef      = 2;
    localparam int unsigned YPerMcuDef     = 4;
    localparam int unsigned McuPerFrameDef = 512;

    // Component selects packed as {v, u, y}
    localparam logic [2:0] SelY = 3'b001;
    localparam logic [2:0] SelU = 3'b010;
    localparam logic [2:0] SelV = 3'b100;

    function automatic logic [2:0] comp_sel(input logic [2:0] idx, input int unsigned y_per_mcu);
        if (32'(idx) < y_per_mcu) begin
            return SelY;
        end else if (32'(idx) == y_per_mcu) begin
            return SelU;
        end
        return SelV;
    endfunction

endpackage

// File: rtl/vlc_blk_sched_mcu_cnt.sv
// Block-in-MCU index and MCU counter with saturation; flags the final V block of the frame.
module vlc_mcu_cnt
    import vlc_blk_sched_pkg::*;
#(
    parameter int unsigned Y_PER_MCU     = YPerMcuDef,
    parameter int unsigned MCU_PER_FRAME = McuPerFrameDef
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       advance_i,
    output logic [2:0] blk_idx_o,
    output logic [9:0] mcu_count_o,
    output logic       last_blk_o
);

    localparam logic [2:0] LastIdx = 3'(Y_PER_MCU + 1);
    localparam logic [9:0] McuMax  = 10'(MCU_PER_FRAME);

    logic [2:0] blk_idx_q, blk_idx_d;
    logic [9:0] mcu_count_q, mcu_count_d;

    always_comb begin
        blk_idx_d   = blk_idx_q;
        mcu_count_d = mcu_count_q;
        if (clear_i) begin
            blk_idx_d   = '0;
            mcu_count_d = '0;
        end else if (advance_i) begin
            if (blk_idx_q == LastIdx) begin
                blk_idx_d = '0;
                if (mcu_count_q != McuMax) begin
                    mcu_count_d = mcu_count_q + 10'd1;
                end
            end else begin
                blk_idx_d = blk_idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            blk_idx_q   <= '0;
            mcu_count_q <= '0;
        end else begin
            blk_idx_q   <= blk_idx_d;
            mcu_count_q <= mcu_count_d;
        end
    end

    assign blk_idx_o   = blk_idx_q;
    assign mcu_count_o = mcu_count_q;
    assign last_blk_o  = (blk_idx_q == LastIdx) && (mcu_count_q == 10'(MCU_PER_FRAME - 1));

endmodule

// File: rtl/vlc_blk_sched.sv
// Feeds 8x8 zigzag blocks into the VLC in 4:2:0 MCU order with a guaranteed eob gap.
// Optional stall counter output enabled by defining VLC_SCHED_STATS_EN.
module vlc_blk_sched
    import vlc_blk_sched_pkg::*;
#(
    parameter int unsigned BLK_LEN       = BlkLenDef,
    parameter int unsigned GAP_CYC       = GapCycDef,
    parameter int unsigned Y_PER_MCU     = YPerMcuDef,
    parameter int unsigned MCU_PER_FRAME = McuPerFrameDef
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        frame_start,
    input  logic        blk_rdy,
    input  logic        pk_ready,
    output logic        rd_en,
    output logic [5:0]  rd_addr,
    output logic        blk_release,
    output logic        den,
    output logic        lumenb_in,
    output logic        chromenb_uin,
    output logic        chromenb_vin,
    output logic [2:0]  blk_idx,
    output logic [9:0]  mcu_count,
    output logic        busy,
`ifdef VLC_SCHED_STATS_EN
    output logic [15:0] stall_cycles,
`endif
    output logic        frame_done
);

    localparam logic [5:0] LastAddr = 6'(BLK_LEN - 1);
    localparam logic [7:0] LastGap  = 8'(GAP_CYC - 1);

    sched_state_e state_q, state_d;
    logic         rd_en_q, rd_en_d;
    logic [5:0]   rd_addr_q, rd_addr_d;
    logic [7:0]   gap_cnt_q, gap_cnt_d;
    logic [2:0]   sel_q, sel_d;
    logic         den_q, den_d;
    logic         release_q, release_d;
    logic         busy_q, busy_d;
    logic         frame_done_q, frame_done_d;
    logic         cnt_clear, cnt_advance, last_blk;
`ifdef VLC_SCHED_STATS_EN
    logic [15:0]  stall_q, stall_d;
`endif

    vlc_mcu_cnt #(
        .Y_PER_MCU     (Y_PER_MCU),
        .MCU_PER_FRAME (MCU_PER_FRAME)
    ) u_mcu_cnt (
        .clk_i       (clk),
        .rst_ni      (nrst),
        .clear_i     (cnt_clear),
        .advance_i   (cnt_advance),
        .blk_idx_o   (blk_idx),
        .mcu_count_o (mcu_count),
        .last_blk_o  (last_blk)
    );

    always_comb begin
        state_d      = state_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        gap_cnt_d    = gap_cnt_q;
        sel_d        = sel_q;
        frame_done_d = frame_done_q;
        cnt_clear    = 1'b0;
        cnt_advance  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d   = StWait;
                    cnt_clear = 1'b1;
                    // Selects become valid on entering WAIT so they are one-hot whenever busy
                    sel_d     = comp_sel(3'd0, Y_PER_MCU);
                end
            end
            StWait: begin
                if (blk_rdy && pk_ready) begin
                    state_d   = StIssue;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    sel_d     = comp_sel(blk_idx, Y_PER_MCU);
                end
            end
            StIssue: begin
                if (rd_addr_q == LastAddr) begin
                    state_d   = StGap;
                    gap_cnt_d = '0;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + 6'd1;
                end
            end
            StGap: begin
                if (gap_cnt_q == LastGap) begin
                    cnt_advance  = 1'b1;
                    state_d      = last_blk ? StDone : StWait;
                    frame_done_d = last_blk;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            StDone: begin
                if (frame_start) begin
                    state_d      = StWait;
                    cnt_clear    = 1'b1;
                    frame_done_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        den_d     = rd_en_q;
        release_d = den_q && !rd_en_q;
        busy_d    = (state_d == StWait) || (state_d == StIssue) || (state_d == StGap);

`ifdef VLC_SCHED_STATS_EN
        stall_d = stall_q;
        if (cnt_clear) begin
            stall_d = '0;
        end else if (state_q == StWait && !(blk_rdy && pk_ready) && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= StIdle;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            gap_cnt_q    <= '0;
            sel_q        <= '0;
            den_q        <= 1'b0;
            release_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef VLC_SCHED_STATS_EN
            stall_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            gap_cnt_q    <= gap_cnt_d;
            sel_q        <= sel_d;
            den_q        <= den_d;
            release_q    <= release_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef VLC_SCHED_STATS_EN
            stall_q      <= stall_d;
`endif
        end
    end

    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign den          = den_q;
    assign blk_release  = release_q;
    assign lumenb_in    = sel_q[0];
    assign chromenb_uin = sel_q[1];
    assign chromenb_vin = sel_q[2];
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
`ifdef VLC_SCHED_STATS_EN
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_vlc_blk_sched.sv
// Directed bench for vlc_blk_sched with a two-MCU frame; stall counter checked when
// VLC_SCHED_STATS_EN is defined.
module tb_vlc_blk_sched;

    logic        clk = 1'b0;
    logic        nrst;
    logic        frame_start, blk_rdy, pk_ready;
    logic        rd_en, blk_release, den, lumenb_in, chromenb_uin, chromenb_vin, busy, frame_done;
    logic [5:0]  rd_addr;
    logic [2:0]  blk_idx;
    logic [9:0]  mcu_count;
`ifdef VLC_SCHED_STATS_EN
    logic [15:0] stall_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vlc_blk_sched #(
        .BLK_LEN       (64),
        .GAP_CYC       (2),
        .Y_PER_MCU     (4),
        .MCU_PER_FRAME (2)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .frame_start  (frame_start),
        .blk_rdy      (blk_rdy),
        .pk_ready     (pk_ready),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .blk_release  (blk_release),
        .den          (den),
        .lumenb_in    (lumenb_in),
        .chromenb_uin (chromenb_uin),
        .chromenb_vin (chromenb_vin),
        .blk_idx      (blk_idx),
        .mcu_count    (mcu_count),
        .busy         (busy),
`ifdef VLC_SCHED_STATS_EN
        .stall_cycles (stall_cycles),
`endif
        .frame_done   (frame_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for rd_en, then follows one full burst up to the release cycle.
    task automatic burst(input logic [2:0] exp_sel, input logic [2:0] exp_idx, input bit chk_gap,
                         input int drop_at, input int fs_at, input string tag);
        int n;
        int bad;
        n = 0;
        while (rd_en !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check({tag, "_start"}, {31'd0, rd_en}, 32'd1);
        check({tag, "_den_pre"}, {31'd0, den}, 32'd0);
        if (chk_gap) check({tag, "_gap"}, {31'd0, n >= 1}, 32'd1);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (rd_en !== 1'b1 || rd_addr !== 6'(i)) bad++;
            if ({chromenb_vin, chromenb_uin, lumenb_in} !== exp_sel) bad++;
            if (blk_idx !== exp_idx || busy !== 1'b1 || blk_release !== 1'b0) bad++;
            if (i == drop_at) blk_rdy = 1'b0;
            frame_start = (i == fs_at);
            step();
            if (den !== 1'b1) bad++;
        end
        frame_start = 1'b0;
        check({tag, "_burst"}, bad, 32'd0);
        check({tag, "_rd_end"}, {31'd0, rd_en}, 32'd0);
        step();
        if (drop_at >= 0) blk_rdy = 1'b1;
        check({tag, "_den_end"}, {31'd0, den}, 32'd0);
        check({tag, "_release"}, {31'd0, blk_release}, 32'd1);
        check({tag, "_sel_eob"}, {29'd0, chromenb_vin, chromenb_uin, lumenb_in}, {29'd0, exp_sel});
    endtask

    initial begin
        logic [2:0] sel;
        int         idx;
        int         n;
        int         bad;

        nrst = 1'b0;
        frame_start = 1'b0;
        blk_rdy = 1'b0;
        pk_ready = 1'b0;
        step();
        step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_den", {30'd0, den, rd_en}, 32'd0);
        check("rst_sel", {29'd0, chromenb_vin, chromenb_uin, lumenb_in}, 32'd0);
        check("rst_cnt", {19'd0, blk_idx, mcu_count}, 32'd0);
        check("rst_misc", {24'd0, rd_addr, blk_release, frame_done}, 32'd0);
        nrst = 1'b1;
        step();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // First frame, always ready: den rises two cycles after WAIT entry
        blk_rdy = 1'b1;
        pk_ready = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("wait_busy", {31'd0, busy}, 32'd1);
        check("wait_rd", {31'd0, rd_en}, 32'd0);
        check("wait_luma", {29'd0, chromenb_vin, chromenb_uin, lumenb_in}, 32'd1);
        step();
        check("issue_rd", {31'd0, rd_en}, 32'd1);
        burst(3'b001, 3'd0, 1'b0, -1, -1, "y0");

        for (int b = 1; b < 12; b++) begin
            idx = b % 6;
            sel = (idx < 4) ? 3'b001 : ((idx == 4) ? 3'b010 : 3'b100);
            burst(sel, 3'(idx), 1'b1, -1, -1, $sformatf("blk%0d", b));
        end
        check("last_gap_done", {31'd0, frame_done}, 32'd0);
        step();
        check("done_flag", {31'd0, frame_done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        check("done_mcu", {22'd0, mcu_count}, 32'd2);
        check("done_idx", {29'd0, blk_idx}, 32'd0);
        step();
        step();
        check("done_quiet", {30'd0, den, rd_en}, 32'd0);

        // New frame from DONE while the packer stalls for 10 WAIT cycles
        pk_ready = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("restart_done", {31'd0, frame_done}, 32'd0);
        check("restart_busy", {31'd0, busy}, 32'd1);
        check("restart_cnt", {19'd0, blk_idx, mcu_count}, 32'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rd_en !== 1'b0 || den !== 1'b0) bad++;
        end
        check("stall_quiet", bad, 32'd0);
        pk_ready = 1'b1;
        step();
        check("stall_resume", {31'd0, rd_en}, 32'd1);
`ifdef VLC_SCHED_STATS_EN
        check("stall_count", {16'd0, stall_cycles}, 32'd10);
`endif
        // blk_rdy drops at coefficient 30, stray frame_start at coefficient 40
        burst(3'b001, 3'd0, 1'b0, 30, 40, "drop_y0");

        // Reset in the middle of the next burst
        n = 0;
        while (rd_en !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("y1_start", {31'd0, rd_en}, 32'd1);
        for (int i = 0; i < 20; i++) step();
        check("y1_addr20", {26'd0, rd_addr}, 32'd20);
        check("y1_idx", {29'd0, blk_idx}, 32'd1);
        nrst = 1'b0;
        #1;
        check("arst_den", {30'd0, den, rd_en}, 32'd0);
        check("arst_sel", {29'd0, chromenb_vin, chromenb_uin, lumenb_in}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        nrst = 1'b1;
        step();
        check("arst_norelease", {31'd0, blk_release}, 32'd0);
        check("arst_idle", {30'd0, busy, rd_en}, 32'd0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("rf_cnt", {19'd0, blk_idx, mcu_count}, 32'd0);
        check("rf_luma", {29'd0, chromenb_vin, chromenb_uin, lumenb_in}, 32'd1);
        burst(3'b001, 3'd0, 1'b0, -1, -1, "rf_y0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
